// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A among NREQ requesters, with
// optional locked bursts of up to MAX_BURST beats per owner.
module dpram_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        ram_addr_a,
  output logic [DATA_W-1:0]        ram_data_in_a,
  output logic                     ram_we_a,
  input  logic [DATA_W-1:0]        ram_data_out_a
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      beat_q, beat_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [NREQ-1:0] gnt_c;
  logic            found;
  logic [IW-1:0]   win;

  // Round-robin search: first requester after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + 1 + k) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + 1 + k) % NREQ);
      end
    end
  end

  // Grant generation and next-state for the ARB/LOCK FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    gnt_c   = '0;
    case (state_q)
      ARB: begin
        if (found) begin
          gnt_c[win] = 1'b1;
          ptr_d      = win;
          if (lock[win] && (MAX_BURST > 1)) begin
            state_d = LOCK;
            owner_d = win;
            beat_d  = 8'd1;
          end
        end
      end
      LOCK: begin
        // Owner keeps the port; everyone else waits. Returning with
        // ptr = owner makes the owner lowest priority next round.
        if (req[owner_q]) begin
          gnt_c[owner_q] = 1'b1;
          beat_d         = beat_q + 8'd1;
          if (!lock[owner_q] || ((beat_q + 8'd1) == 8'(MAX_BURST))) begin
            state_d = ARB;
            ptr_d   = owner_q;
          end
        end else begin
          state_d = ARB;
          ptr_d   = owner_q;
        end
      end
      default: state_d = ARB;
    endcase
    // No grants can escape while the block is held in reset.
    if (!rst_n) gnt_c = '0;
  end

  // Read beats produce rvalid one cycle later, matching RAM latency.
  always_comb begin
    rvalid_d = gnt_c & ~we;
  end

  // Steer the granted requester onto RAM port A; idle port drives zeros.
  always_comb begin
    ram_addr_a    = '0;
    ram_data_in_a = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        ram_addr_a    = addr[i*ADDR_W +: ADDR_W];
        ram_data_in_a = wdata[i*DATA_W +: DATA_W];
      end
    end
    ram_we_a = |(gnt_c & we);
  end

  // State registers; reset leaves ptr at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      ptr_q    <= IW'(NREQ - 1);
      owner_q  <= '0;
      beat_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt    = gnt_c;
  assign rvalid = rvalid_q;
  assign rdata  = ram_data_out_a;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a 1-cycle-latency RAM model.
module tb_dpram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, lock, we;
  logic [31:0] addr, wdata;
  logic [3:0]  gnt, rvalid;
  logic [7:0]  rdata, ram_addr_a, ram_data_in_a, ram_data_out_a;
  logic        ram_we_a;

  logic [7:0]  mem [256];
  int          errs = 0;
  int          nchk = 0;

  dpram_port_arbiter #(.NREQ(4), .ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr_a(ram_addr_a), .ram_data_in_a(ram_data_in_a),
    .ram_we_a(ram_we_a), .ram_data_out_a(ram_data_out_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM port A: write at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_in_a;
    ram_data_out_a <= mem[ram_addr_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rr_seq [8];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0; req = 4'b1111; lock = '0; we = 4'b1111; addr = '0; wdata = '0;

    // Reset hold: nothing granted, no write, no rvalid.
    tick(); tick();
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'h0);
    chk("rst_we", {31'd0, ram_we_a}, 32'h0);
    chk("rst_rvalid", {28'd0, rvalid}, 32'h0);

    // Release and round-robin over all four readers.
    tick();
    rst_n = 1'b1; we = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_gnt%0d", i), {28'd0, gnt}, {28'd0, rr_seq[i]});
      chk($sformatf("rr_rvalid%0d", i), {28'd0, rvalid}, (i == 0) ? 32'h0 : {28'd0, rr_seq[i-1]});
      tick();
    end

    // Requester 0 writes A5 to 0x10, requester 2 reads it back.
    req = 4'b0001; we = 4'b0001; addr[7:0] = 8'h10; wdata[7:0] = 8'hA5;
    #1;
    chk("wr_gnt", {28'd0, gnt}, 32'h1);
    chk("wr_we", {31'd0, ram_we_a}, 32'h1);
    chk("wr_addr", {24'd0, ram_addr_a}, 32'h10);
    chk("wr_data", {24'd0, ram_data_in_a}, 32'hA5);
    tick();
    req = 4'b0100; we = 4'b0000; addr[23:16] = 8'h10;
    #1;
    chk("rd_gnt", {28'd0, gnt}, 32'h4);
    chk("rd_we", {31'd0, ram_we_a}, 32'h0);
    chk("rd_addr", {24'd0, ram_addr_a}, 32'h10);
    chk("wr_no_rvalid", {28'd0, rvalid}, 32'h0);
    tick();
    req = 4'b0000;
    #1;
    chk("rd_rvalid", {28'd0, rvalid}, 32'h4);
    chk("rd_rdata", {24'd0, rdata}, 32'hA5);
    chk("idle_addr", {24'd0, ram_addr_a}, 32'h0);
    chk("idle_gnt", {28'd0, gnt}, 32'h0);
    tick();

    // Put ptr on 0, then a locked burst from requester 1 runs 4 beats.
    req = 4'b0001;
    #1;
    chk("ptr0_gnt", {28'd0, gnt}, 32'h1);
    tick();
    req = 4'b0111; lock = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("burst_gnt%0d", i), {28'd0, gnt}, 32'h2);
      tick();
    end
    #1;
    chk("burst_after", {28'd0, gnt}, 32'h4);
    tick();

    // Reset in beat 2 of a requester 1 burst.
    req = 4'b0010; lock = 4'b0010;
    #1;
    chk("mid_beat1", {28'd0, gnt}, 32'h2);
    tick();
    #1;
    chk("mid_beat2", {28'd0, gnt}, 32'h2);
    chk("mid_rvalid", {28'd0, rvalid}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", {28'd0, gnt}, 32'h0);
    chk("mid_rst_rvalid", {28'd0, rvalid}, 32'h0);
    tick();
    rst_n = 1'b1; req = 4'b0011; lock = '0;
    #1;
    chk("mid_release", {28'd0, gnt}, 32'h1);
    tick();

    // Single requester 3: five back-to-back writes.
    req = 4'b1000; we = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      addr[31:24] = 8'h20 + 8'(i); wdata[31:24] = 8'h30 + 8'(i);
      #1;
      chk($sformatf("solo_gnt%0d", i), {28'd0, gnt}, 32'h8);
      chk($sformatf("solo_addr%0d", i), {24'd0, ram_addr_a}, 32'h20 + i);
      chk($sformatf("solo_we%0d", i), {31'd0, ram_we_a}, 32'h1);
      tick();
    end
    req = 4'b0001; we = 4'b0000; addr[7:0] = 8'h22;
    #1;
    chk("solo_rd_gnt", {28'd0, gnt}, 32'h1);
    tick();
    req = 4'b0000;
    #1;
    chk("solo_rd_rvalid", {28'd0, rvalid}, 32'h1);
    chk("solo_rd_rdata", {24'd0, rdata}, 32'h32);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
